// File: rtl/decode_issue.sv
// Decode/issue stage: 16x32 register file, busy scoreboard and one-deep issue register toward the ALU.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data to a busy source operand.
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_in1,
    output logic [31:0] out_in2,
    output logic [4:0]  out_alu_ctrl,
    output logic [3:0]  out_rd,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        illegal,
    output logic [7:0]  err_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned IMM_W  = 10;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_DIV   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_DEC   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_ENCRY = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_DECRY = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_IMMED = OPC_W'(12);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_in1_q, out_in1_d;
    logic [DATA_W-1:0] out_in2_q, out_in2_d;
    logic [OPC_W-1:0]  out_alu_ctrl_q, out_alu_ctrl_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;
    logic              is_legal, use_rs1, use_rs2, is_immed;
    logic              fwd1, fwd2, hazard;
    logic [DATA_W-1:0] src1_val, src2_val, op1, op2;
    logic              accept, issue, ill_accept;

    // Field extraction and operand-usage decode
    always_comb begin
        opcode   = in_instr[18:14];
        rd       = in_instr[13:10];
        rs1      = in_instr[9:6];
        rs2      = in_instr[5:2];
        imm      = in_instr[9:0];
        is_legal = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_immed = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_INC, OP_DEC, OP_NOT, OP_ENCRY, OP_DECRY: use_rs1 = 1'b1;
            OP_IMMED: is_immed = 1'b1;
            default:  is_legal = 1'b0;
        endcase
    end

    // Writeback forwarding only rescues a busy source; rd conflicts always stall
`ifdef DECODE_BYPASS_EN
    assign fwd1 = wb_en && (wb_addr == rs1) && busy_q[rs1];
    assign fwd2 = wb_en && (wb_addr == rs2) && busy_q[rs2];
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign src1_val = fwd1 ? wb_data : rf_q[rs1];
    assign src2_val = fwd2 ? wb_data : rf_q[rs2];

    // Hazard, handshake and operand selection
    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && busy_q[rs1] && !fwd1) hazard = 1'b1;
        if (use_rs2 && busy_q[rs2] && !fwd2) hazard = 1'b1;
        if (busy_q[rd])                      hazard = 1'b1;

        in_ready = 1'b0;
        if (rst_n) begin
            if (is_legal) in_ready = (!out_valid_q || out_ready) && !hazard;
            else          in_ready = 1'b1;
        end

        accept     = in_valid && in_ready;
        issue      = accept && is_legal;
        ill_accept = accept && !is_legal;

        op1 = '0;
        op2 = '0;
        if (is_immed) begin
            op2 = DATA_W'(imm);
        end else begin
            if (use_rs1) op1 = src1_val;
            if (use_rs2) op2 = src2_val;
        end
    end

    // Next-state for issue register, scoreboard, register file and error counter
    always_comb begin
        out_valid_d    = out_valid_q;
        out_in1_d      = out_in1_q;
        out_in2_d      = out_in2_q;
        out_alu_ctrl_d = out_alu_ctrl_q;
        out_rd_d       = out_rd_q;
        busy_d         = busy_q;
        rf_d           = rf_q;
        illegal_d      = ill_accept;
        err_cnt_d      = err_cnt_q;

        if (issue) begin
            out_valid_d    = 1'b1;
            out_in1_d      = op1;
            out_in2_d      = op2;
            out_alu_ctrl_d = opcode;
            out_rd_d       = rd;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (wb_en) begin
            rf_d[wb_addr]   = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        // Issue after writeback so a same-cycle set on the same register wins
        if (issue) busy_d[rd] = 1'b1;

        if (ill_accept && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_in1_q      <= '0;
            out_in2_q      <= '0;
            out_alu_ctrl_q <= '0;
            out_rd_q       <= '0;
            busy_q         <= '0;
            illegal_q      <= 1'b0;
            err_cnt_q      <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_in1_q      <= out_in1_d;
            out_in2_q      <= out_in2_d;
            out_alu_ctrl_q <= out_alu_ctrl_d;
            out_rd_q       <= out_rd_d;
            busy_q         <= busy_d;
            illegal_q      <= illegal_d;
            err_cnt_q      <= err_cnt_d;
            rf_q           <= rf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_in1      = out_in1_q;
    assign out_in2      = out_in2_q;
    assign out_alu_ctrl = out_alu_ctrl_q;
    assign out_rd       = out_rd_q;
    assign illegal      = illegal_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: the driver pushes expected issues into a queue,
// a negedge monitor pops and compares on every out_valid && out_ready transfer.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [18:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_in1, out_in2;
    logic [4:0]  out_alu_ctrl;
    logic [3:0]  out_rd;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        illegal;
    logic [7:0]  err_cnt;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_in1(out_in1), .out_in2(out_in2), .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .illegal(illegal), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  ctrl;
        logic [3:0]  rd;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_INC = 5'd4, OP_AND = 5'd6,
                           OP_OR = 5'd7, OP_XOR = 5'd8, OP_NOT = 5'd9, OP_IMMED = 5'd12;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [18:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    function automatic logic [18:0] mki(input logic [4:0] op, input logic [3:0] rd, input logic [9:0] imm);
        return {op, rd, imm};
    endfunction

    // Monitor: every completed transfer must match the oldest expected issue
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got rd %0h with empty scoreboard at %0t", out_rd, $time);
            end else begin
                e = sb.pop_front();
                check("out_in1", out_in1, e.in1);
                check("out_in2", out_in2, e.in2);
                check("out_alu_ctrl", 32'(out_alu_ctrl), 32'(e.ctrl));
                check("out_rd", 32'(out_rd), 32'(e.rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] addr, input logic [31:0] data);
        wb_en = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    // Present an instruction, wait for acceptance, expect out_valid one cycle later
    task automatic issue(input logic [18:0] instr, input logic [31:0] e1, input logic [31:0] e2);
        int waited = 0;
        exp_t e;
        in_instr = instr;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 for instr %0h", instr);
            in_valid = 1'b0;
            tick();
            return;
        end
        e.in1 = e1;
        e.in2 = e2;
        e.ctrl = instr[18:14];
        e.rd = instr[13:10];
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_rd", 32'(out_rd), 32'(e.rd));
    endtask

    initial begin : watchdog
        #60000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        // Reset state, and no accept while held in reset
        #2 rst_n = 1'b0;
        in_instr = mk(OP_ADD, 4'd3, 4'd1, 4'd2);
        in_valid = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_out_in1", out_in1, 32'd0);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;

        // Writeback then ADD
        wb(4'd1, 32'd5);
        wb(4'd2, 32'd7);
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 32'd5, 32'd7);
        check("busy3_set", 32'(dut.busy_q[3]), 32'd1);

        // RAW on R3: stall until writeback of 12
        in_instr = mk(OP_SUB, 4'd5, 4'd3, 4'd2);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raw_stall", 32'(in_ready), 32'd0);
            tick();
        end
        wb_en = 1'b1;
        wb_addr = 4'd3;
        wb_data = 32'd12;
        @(negedge clk);
`ifdef DECODE_BYPASS_EN
        check("raw_bypass_ready", 32'(in_ready), 32'd1);
`else
        check("raw_wb_cycle_stall", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        check("raw_after_wb_ready", 32'(in_ready), 32'd1);
`endif
        e = '{in1: 32'd12, in2: 32'd7, ctrl: OP_SUB, rd: 4'd5};
        sb.push_back(e);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        check("raw_issue_valid", 32'(out_valid), 32'd1);
        check("raw_issue_rd", 32'(out_rd), 32'd5);
        wb(4'd5, 32'h55);

        // IMMED, NOT, XOR, INC
        issue(mki(OP_IMMED, 4'd4, 10'h3FF), 32'd0, 32'd1023);
        wb(4'd4, 32'd9);
        issue(mk(OP_NOT, 4'd6, 4'd4, 4'd0), 32'd9, 32'd0);
        issue(mk(OP_XOR, 4'd7, 4'd1, 4'd4), 32'd5, 32'd9);
        issue(mk(OP_INC, 4'd10, 4'd2, 4'd0), 32'd7, 32'd0);
        wb(4'd6, 32'd1);
        wb(4'd7, 32'd2);
        wb(4'd10, 32'd3);

        // WAW: busy rd stalls even in the cycle its writeback arrives
        issue(mki(OP_IMMED, 4'd11, 10'd5), 32'd0, 32'd5);
        in_instr = mki(OP_IMMED, 4'd11, 10'd6);
        in_valid = 1'b1;
        wb_en = 1'b1;
        wb_addr = 4'd11;
        wb_data = 32'd0;
        @(negedge clk);
        check("waw_stall_on_wb", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        issue(mki(OP_IMMED, 4'd11, 10'd6), 32'd0, 32'd6);
        wb(4'd11, 32'd0);

        // Backpressure: outputs frozen, second instruction waits, then both drain back-to-back
        out_ready = 1'b0;
        issue(mk(OP_AND, 4'd8, 4'd1, 4'd2), 32'd5, 32'd7);
        in_instr = mk(OP_OR, 4'd9, 4'd2, 4'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_rd", 32'(out_rd), 32'd8);
            check("bp_hold_in1", out_in1, 32'd5);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        e = '{in1: 32'd7, in2: 32'd5, ctrl: OP_OR, rd: 4'd9};
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_rd", 32'(out_rd), 32'd9);
        wb(4'd8, 32'd0);
        wb(4'd9, 32'd0);
        tick();

        // Illegal opcodes: 13 first, then 20; counter saturates at 255
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_instr = (i == 0) ? mk(5'd13, 4'd1, 4'd0, 4'd0) : mk(5'd20, 4'd1, 4'd0, 4'd0);
            @(negedge clk);
            check("ill_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("ill_pulse", 32'(illegal), 32'd1);
            check("ill_no_issue", 32'(out_valid), 32'd0);
            check("ill_err_cnt", 32'(err_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("ill_pulse_end", 32'(illegal), 32'd0);

        // Reset mid-operation with a pending issue and busy[3]
        out_ready = 1'b0;
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 32'd5, 32'd7);
        check("pre_rst_busy3", 32'(dut.busy_q[3]), 32'd1);
        in_instr = mk(OP_ADD, 4'd2, 4'd1, 4'd1);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(dut.busy_q), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(mk(OP_ADD, 4'd2, 4'd1, 4'd1), 32'd0, 32'd0);

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_instr, input, 19 bits: instruction. Opcode [18:14], rd [13:10], rs1 [9:6], rs2 [5:2], imm10 [9:0].
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): instruction handshake.
REQ-005 SHALL have ports out_in1 (output, 32), out_in2 (output, 32), out_alu_ctrl (output, 5) and out_rd (output, 4): ALU operands, operation and destination.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): issue handshake toward the ALU.
REQ-007 SHALL have ports wb_en (input, 1), wb_addr (input, 4) and wb_data (input, 32): result writeback.
REQ-008 SHALL have ports illegal (output, 1), a one-cycle pulse, and err_cnt (output, 8): illegal-opcode count.

Function
REQ-009 SHALL hold a 16x32 register file and a 16-bit busy scoreboard.
REQ-010 SHALL decode the opcode as: ADD=0, SUB=1, MUL=2, DIV=3, INC=4, DEC=5, AND=6, OR=7, XOR=8, NOT=9, ENCRY=10, DECRY=11, IMMED=12.
REQ-011 SHALL treat opcodes 13-31 as illegal.
REQ-012 SHALL use binary ops (0-3, 6-8) as: rs1 and rs2 sources, out_in1=R[rs1], out_in2=R[rs2].
REQ-013 SHALL use unary ops (4, 5, 9-11) as: rs1 source only, out_in1=R[rs1], out_in2=0.
REQ-014 SHALL issue IMMED with out_in1=0 and out_in2=zero-extended imm10, with no source operands.
REQ-015 SHALL raise a hazard when any used source is busy, or when busy[rd] is set (WAW).
REQ-016 SHALL drive in_ready=(!out_valid || out_ready) && !hazard for legal opcodes.
REQ-017 SHALL drive in_ready=1 for illegal opcodes.
REQ-018 SHALL issue on in_valid && in_ready with a legal opcode: register the out_* fields, set out_valid=1 and set busy[rd]. Latency is one cycle, from instruction accept to out_valid.
REQ-019 SHALL clear out_valid after out_valid && out_ready unless a new issue happens in the same cycle.
REQ-020 SHALL hold out_* fields stable while out_valid && !out_ready.
REQ-021 SHALL, on accepting an illegal opcode, produce no issue, pulse illegal for one cycle and increment err_cnt, saturating at 255.
REQ-022 SHALL, on wb_en, write R[wb_addr]=wb_data and clear busy[wb_addr].
REQ-023 SHALL let the set win when an issue sets busy[x] and a writeback clears busy[x] in the same cycle.
REQ-024 SHALL give register-file reads the value stored before the current edge; same-cycle forwarding is covered only under REQ-028.
REQ-025 SHALL issue back-to-back, one instruction per cycle, when out_ready=1 and there is no hazard.

Reset
REQ-026 SHALL, while rst_n=0, immediately force:
- out_valid=0 and illegal=0;
- out_in1, out_in2, out_alu_ctrl and out_rd to 0;
- err_cnt=0 and all busy bits=0;
- all 16 registers to 0.
REQ-027 SHALL drive in_ready=0 during reset, and SHALL discard any in-flight issue; the first accept occurs on the first rising edge after rst_n rises.

Configuration
REQ-028 SHALL, when macro DECODE_BYPASS_EN is defined, clear the hazard for a busy source (not rd) equal to wb_addr while wb_en=1, and take wb_data as that operand in the same cycle.
REQ-029 SHALL, when DECODE_BYPASS_EN is undefined, stall such a source until the cycle after writeback; issue then happens no earlier than one cycle after wb_en.

Verification
REQ-030 SHALL cover writeback then ADD: wb R1=5, wb R2=7 -> ADD rd=3 rs1=1 rs2=2 gives out_in1=5, out_in2=7, out_alu_ctrl=0, out_rd=3 one cycle after accept, and busy[3]=1.
REQ-031 SHALL cover the RAW hazard: ADD rd=3 issued, then SUB rs1=3 presented -> in_ready=0 until wb_en addr=3 data=12. With bypass, SUB issues that same cycle with out_in1=12; without bypass, one cycle later.
REQ-032 SHALL cover IMMED and NOT: IMMED rd=4 imm10=0x3FF -> out_in1=0, out_in2=1023. NOT rs1=4 (R4=9) -> out_in2=0, out_alu_ctrl=9.
REQ-033 SHALL cover illegal opcodes: opcode 20 presented 300 times -> illegal pulses each accept, no out_valid, err_cnt saturates at 255.
REQ-034 SHALL cover backpressure: out_ready=0 with a second legal instruction waiting -> outputs frozen, in_ready=0. out_ready=1 -> both issue on consecutive cycles.
REQ-035 SHALL cover reset mid-operation: rst_n low while out_valid=1 and busy[3]=1 -> out_valid=0, busy=0, err_cnt=0 and R1 reads 0 afterwards.
